instr_loader: RTL and testbench

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/instr_loader.sv | 152 +++++++++++++++
 tb/tb_instr_loader.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU package.
// Purpose: opcode constants used by the control decoder and by the program
// loader, plus the legal-opcode predicate both of them rely on.
// Ports: none (package).
package cpu_pkg;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_ADD  = 8'h08;
  localparam logic [7:0] OP_MUL  = 8'h18;
  localparam logic [7:0] OP_ADDI = 8'h03;
  localparam logic [7:0] OP_SW   = 8'h19;
  localparam logic [7:0] OP_LW   = 8'h31;
  localparam logic [7:0] OP_JAL  = 8'h04;

  // True when the control decoder defines this opcode.
  function automatic logic opcode_legal(input logic [7:0] op);
    logic legal;
    legal = 1'b0;
    case (op)
      OP_NOP, OP_ADD, OP_MUL, OP_ADDI, OP_SW, OP_LW, OP_JAL: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/instr_loader.sv
// instr_loader
// Purpose: receives a program over a byte stream (count byte N, then N
// little-endian 32-bit words), writes each word into instruction memory,
// holds the CPU stalled while loading and flags words whose opcode the
// control decoder does not define.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   load_start        one-cycle request to start a load (honoured in IDLE only)
//   rx_data/rx_valid  incoming byte stream; rx_ready is the loader's handshake
//   imem_we/addr/wdata instruction-memory write port (one strobe per word)
//   cpu_stall         high while a load is in progress
//   done              one-cycle pulse when the load finishes
//   err, bad_cnt      sticky illegal-opcode flag and saturating count
module instr_loader
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [7:0]  imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_stall,
  output logic        done,
  output logic        err,
  output logic [7:0]  bad_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_BYTE,
    S_WRITE,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic        rx_ready_q;
  logic        imem_we_q;
  logic [7:0]  imem_addr_q;
  logic [31:0] imem_wdata_q;
  logic        cpu_stall_q;
  logic        done_q;
  logic        err_q;
  logic [7:0]  bad_cnt_q;
  logic [7:0]  n_q;
  logic [7:0]  word_idx_q;
  logic [1:0]  byte_idx_q;
  // Lanes 0..2 of the word being assembled; lane 3 goes straight into the
  // write-data register together with the other three.
  logic [23:0] word_q;
  logic        xfer;

  // rx_ready_q is high exactly in COUNT and BYTE, so this is the handshake.
  assign xfer = rx_valid && rx_ready_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (load_start) state_d = S_COUNT;
      S_COUNT: if (xfer) state_d = (rx_data == 8'd0) ? S_DONE : S_BYTE;
      S_BYTE:  if (xfer && (byte_idx_q == 2'd3)) state_d = S_WRITE;
      S_WRITE: state_d = (word_idx_q == n_q - 8'd1) ? S_DONE : S_BYTE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the
  // state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rx_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= 8'd0;
      imem_wdata_q <= 32'd0;
      cpu_stall_q  <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      bad_cnt_q    <= 8'd0;
      n_q          <= 8'd0;
      word_idx_q   <= 8'd0;
      byte_idx_q   <= 2'd0;
      word_q       <= 24'd0;
    end else begin
      state_q     <= state_d;
      rx_ready_q  <= (state_d == S_COUNT) || (state_d == S_BYTE);
      imem_we_q   <= (state_d == S_WRITE);
      cpu_stall_q <= (state_d != S_IDLE);
      done_q      <= (state_d == S_DONE);

      case (state_q)
        S_IDLE: begin
          if (load_start) begin
            err_q      <= 1'b0;
            bad_cnt_q  <= 8'd0;
            word_idx_q <= 8'd0;
            byte_idx_q <= 2'd0;
          end
        end
        S_COUNT: begin
          if (xfer) begin
            n_q        <= rx_data;
            word_idx_q <= 8'd0;
            byte_idx_q <= 2'd0;
          end
        end
        S_BYTE: begin
          if (xfer) begin
            byte_idx_q <= byte_idx_q + 2'd1;
            case (byte_idx_q)
              2'd0: word_q[7:0]   <= rx_data;
              2'd1: word_q[15:8]  <= rx_data;
              2'd2: word_q[23:16] <= rx_data;
              default: begin
                // Final byte: present the full word during WRITE.
                imem_addr_q  <= word_idx_q;
                imem_wdata_q <= {rx_data, word_q};
              end
            endcase
          end
        end
        S_WRITE: begin
          // The word is written regardless; an unknown opcode is only flagged.
          if (!opcode_legal(imem_wdata_q[31:24])) begin
            err_q <= 1'b1;
            if (bad_cnt_q != 8'hFF) bad_cnt_q <= bad_cnt_q + 8'd1;
          end
          if (word_idx_q != n_q - 8'd1) begin
            word_idx_q <= word_idx_q + 8'd1;
            byte_idx_q <= 2'd0;
          end
        end
        default: ;
      endcase
    end
  end

  assign rx_ready   = rx_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_stall  = cpu_stall_q;
  assign done       = done_q;
  assign err        = err_q;
  assign bad_cnt    = bad_cnt_q;

endmodule

// File: tb/tb_instr_loader.sv
module tb_instr_loader;

  logic        clk;
  logic        rst;
  logic        load_start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_stall;
  logic        done;
  logic        err;
  logic [7:0]  bad_cnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_xfer = 0;

  // Write / done / stall log captured from the DUT pins
  logic [7:0]  wa[$];
  logic [31:0] wd[$];
  int          wc[$];
  int          done_n;
  int          done_cyc;
  int          stall_n;

  instr_loader dut (
    .clk       (clk),
    .rst       (rst),
    .load_start(load_start),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_stall (cpu_stall),
    .done      (done),
    .err       (err),
    .bad_cnt   (bad_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (imem_we) begin
      wa.push_back(imem_addr);
      wd.push_back(imem_wdata);
      wc.push_back(cyc);
      $display("[%0t] write addr=%0d data=%08h", $time, imem_addr, imem_wdata);
    end
    if (done) begin
      done_n   = done_n + 1;
      done_cyc = cyc;
    end
    if (cpu_stall) stall_n = stall_n + 1;
  end

  task automatic clear_log();
    wa.delete(); wd.delete(); wc.delete();
    done_n = 0; done_cyc = -1; stall_n = 0;
  endtask

  task automatic start_load();
    @(posedge clk); #1 load_start = 1'b1;
    @(posedge clk); #1 load_start = 1'b0;
  endtask

  // Present one byte and wait (bounded) for the edge that transfers it.
  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      if (rx_ready) begin
        @(posedge clk); #1;
        last_xfer = cyc;
        ok = 1'b1;
      end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL send_byte_timeout actual=rx_ready_low required=rx_ready_high");
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      logic [31:0] t;
      t = w >> (8 * k);
      send_byte(t[7:0]);
    end
  endtask

  task automatic wait_done();
    for (int n = 0; n < 60 && done_n == 0; n++) @(negedge clk);
    rx_valid = 1'b0;
    checks++;
    if (done_n !== 1) begin
      failures++;
      $display("FAIL done_seen actual=%0d required=1", done_n);
    end
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; load_start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    clear_log();
    repeat (2) @(negedge clk);
    checks++; if ({rx_ready, imem_we, cpu_stall, done, err} !== 5'b0) begin
      failures++; $display("FAIL reset_flags actual=%b required=00000", {rx_ready, imem_we, cpu_stall, done, err}); end
    checks++; if (imem_addr !== 8'd0) begin
      failures++; $display("FAIL reset_addr actual=%0d required=0", imem_addr); end
    checks++; if (imem_wdata !== 32'd0) begin
      failures++; $display("FAIL reset_wdata actual=%08h required=00000000", imem_wdata); end
    checks++; if (bad_cnt !== 8'd0) begin
      failures++; $display("FAIL reset_bad_cnt actual=%0d required=0", bad_cnt); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (rx_ready !== 1'b0 || cpu_stall !== 1'b0) begin
      failures++; $display("FAIL idle_outputs actual=%b%b required=00", rx_ready, cpu_stall); end
    $display("test_reset done");
  endtask

  task automatic test_two_words();
    clear_log();
    start_load();
    send_byte(8'd2);
    send_word(32'h00000008);
    send_word(32'h31000003);
    wait_done();
    checks++; if (wa.size() !== 2) begin
      failures++; $display("FAIL two_words_count actual=%0d required=2", wa.size()); end
    if (wa.size() == 2) begin
      checks++; if (wa[0] !== 8'd0 || wd[0] !== 32'h00000008) begin
        failures++; $display("FAIL two_words_w0 actual=%0d:%08h required=0:00000008", wa[0], wd[0]); end
      checks++; if (wa[1] !== 8'd1 || wd[1] !== 32'h31000003) begin
        failures++; $display("FAIL two_words_w1 actual=%0d:%08h required=1:31000003", wa[1], wd[1]); end
      checks++; if (wc[1] - wc[0] !== 5) begin
        failures++; $display("FAIL two_words_throughput actual=%0d required=5", wc[1] - wc[0]); end
    end
    checks++; if (err !== 1'b0 || bad_cnt !== 8'd0) begin
      failures++; $display("FAIL two_words_err actual=%b/%0d required=0/0", err, bad_cnt); end
    checks++; if (imem_addr !== 8'd1 || imem_wdata !== 32'h31000003 || imem_we !== 1'b0) begin
      failures++; $display("FAIL two_words_hold actual=%0d:%08h we=%b required=1:31000003 we=0", imem_addr, imem_wdata, imem_we); end
    $display("test_two_words done");
  endtask

  task automatic test_illegal();
    int xc;
    clear_log();
    start_load();
    send_byte(8'd1);
    send_word(32'hFF000000);
    xc = last_xfer;
    wait_done();
    checks++; if (wa.size() !== 1) begin
      failures++; $display("FAIL illegal_count actual=%0d required=1", wa.size()); end
    if (wa.size() == 1) begin
      checks++; if (wa[0] !== 8'd0 || wd[0] !== 32'hFF000000) begin
        failures++; $display("FAIL illegal_word actual=%0d:%08h required=0:ff000000", wa[0], wd[0]); end
      checks++; if (wc[0] !== xc) begin
        failures++; $display("FAIL illegal_latency actual=%0d required=%0d", wc[0], xc); end
      checks++; if (done_cyc !== wc[0] + 1) begin
        failures++; $display("FAIL illegal_done_timing actual=%0d required=%0d", done_cyc, wc[0] + 1); end
    end
    checks++; if (err !== 1'b1 || bad_cnt !== 8'd1) begin
      failures++; $display("FAIL illegal_err actual=%b/%0d required=1/1", err, bad_cnt); end
    $display("test_illegal done");
  endtask

  task automatic test_zero();
    int xc;
    clear_log();
    start_load();
    send_byte(8'd0);
    xc = last_xfer;
    wait_done();
    checks++; if (wa.size() !== 0) begin
      failures++; $display("FAIL zero_writes actual=%0d required=0", wa.size()); end
    checks++; if (done_cyc !== xc) begin
      failures++; $display("FAIL zero_done_timing actual=%0d required=%0d", done_cyc, xc); end
    checks++; if (stall_n !== 2) begin
      failures++; $display("FAIL zero_stall_cycles actual=%0d required=2", stall_n); end
    checks++; if (err !== 1'b0 || bad_cnt !== 8'd0) begin
      failures++; $display("FAIL zero_err_cleared actual=%b/%0d required=0/0", err, bad_cnt); end
    $display("test_zero done");
  endtask

  task automatic test_toggle();
    logic [31:0] words [3];
    words[0] = 32'h18123456; words[1] = 32'h04ABCDEF; words[2] = 32'h19000001;
    clear_log();
    start_load();
    send_byte(8'd3);
    rx_valid = 1'b0; @(posedge clk); #1;
    for (int w = 0; w < 3; w++) begin
      for (int k = 0; k < 4; k++) begin
        logic [31:0] t;
        t = words[w] >> (8 * k);
        send_byte(t[7:0]);
        rx_valid = 1'b0; @(posedge clk); #1;
      end
    end
    wait_done();
    checks++; if (wa.size() !== 3) begin
      failures++; $display("FAIL toggle_count actual=%0d required=3", wa.size()); end
    if (wa.size() == 3) begin
      for (int w = 0; w < 3; w++) begin
        checks++; if (wa[w] !== w[7:0] || wd[w] !== words[w]) begin
          failures++; $display("FAIL toggle_w%0d actual=%0d:%08h required=%0d:%08h", w, wa[w], wd[w], w, words[w]); end
      end
    end
    checks++; if (err !== 1'b0) begin
      failures++; $display("FAIL toggle_err actual=%b required=0", err); end
    $display("test_toggle done");
  endtask

  task automatic test_reset_midload();
    clear_log();
    start_load();
    send_byte(8'd4);
    send_word(32'h08000011);
    send_byte(8'h22);
    send_byte(8'h33);
    rst = 1'b1;
    #1;
    checks++; if ({rx_ready, imem_we, cpu_stall, done, err} !== 5'b0 || imem_addr !== 8'd0 || imem_wdata !== 32'd0 || bad_cnt !== 8'd0) begin
      failures++; $display("FAIL midload_reset_outputs actual=%b %0d %08h %0d required=00000 0 00000000 0",
                           {rx_ready, imem_we, cpu_stall, done, err}, imem_addr, imem_wdata, bad_cnt); end
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (wa.size() !== 1 || done_n !== 0) begin
      failures++; $display("FAIL midload_abandon actual=writes%0d/done%0d required=writes1/done0", wa.size(), done_n); end
    if (wa.size() == 1) begin
      checks++; if (wd[0] !== 32'h08000011) begin
        failures++; $display("FAIL midload_w0 actual=%08h required=08000011", wd[0]); end
    end
    clear_log();
    start_load();
    send_byte(8'd1);
    send_word(32'h08000055);
    wait_done();
    checks++; if (wa.size() !== 1) begin
      failures++; $display("FAIL reload_count actual=%0d required=1", wa.size()); end
    if (wa.size() == 1) begin
      checks++; if (wa[0] !== 8'd0 || wd[0] !== 32'h08000055) begin
        failures++; $display("FAIL reload_word actual=%0d:%08h required=0:08000055", wa[0], wd[0]); end
    end
    $display("test_reset_midload done");
  endtask

  task automatic test_start_ignored();
    clear_log();
    start_load();
    send_byte(8'd2);
    send_byte(8'h10);
    load_start = 1'b1;
    send_byte(8'h00);
    load_start = 1'b0;
    send_byte(8'h00);
    send_byte(8'hAA);
    send_word(32'hBB000020);
    wait_done();
    checks++; if (wa.size() !== 2) begin
      failures++; $display("FAIL ignored_count actual=%0d required=2", wa.size()); end
    if (wa.size() == 2) begin
      checks++; if (wd[0] !== 32'hAA000010 || wd[1] !== 32'hBB000020 || wa[1] !== 8'd1) begin
        failures++; $display("FAIL ignored_words actual=%08h,%0d:%08h required=aa000010,1:bb000020", wd[0], wa[1], wd[1]); end
    end
    checks++; if (err !== 1'b1 || bad_cnt !== 8'd2) begin
      failures++; $display("FAIL ignored_err actual=%b/%0d required=1/2", err, bad_cnt); end
    $display("test_start_ignored done");
  endtask

  initial begin
    test_reset();
    test_two_words();
    test_illegal();
    test_zero();
    test_toggle();
    test_reset_midload();
    test_start_ignored();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
